polyvec_acc_reduce_k: RTL and testbench

Parametrised streaming accumulator that follows the basemul stage. It receives KYBER_K polynomials of Montgomery-domain basemul products as coefficient pairs and sums them (add or subtract) into an internal pair-wide accumulator. It then streams out the Barrett-reduced result pair by pair. It replaces the fixed K=3 RAM-C accumulate and reduce path, adding valid/ready handshakes on both sides, K=2..4, and subtract mode.

---
 rtl/polyvec_acc_reduce_k.sv | 181 ++++++++++++++++++
 tb/tb_polyvec_acc_reduce_k.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyvec_acc_reduce_k.sv
// rtl/polyvec_acc_reduce_k.sv - streaming K-polynomial accumulator with Barrett-reduced pair output
module polyvec_acc_reduce_k #(
  parameter int KYBER_K   = 3,
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 16,
  parameter int Q         = 3329,
  parameter int BARRETT_V = 20159
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             negate,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_coef_1,
  input  logic [WIDTH-1:0] in_coef_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_coef_1,
  output logic [WIDTH-1:0] out_coef_2,
  output logic [DEPTH-1:0] out_index,
  output logic [2:0]       k_cnt,
  output logic             busy,
  output logic             done
);

  localparam int NP  = 2 ** (DEPTH - 1);
  localparam int PCW = DEPTH - 1;
  // Product width wide enough for BARRETT_V * a plus the rounding term
  localparam int PW  = (WIDTH + 18 > 32) ? WIDTH + 18 : 32;

  localparam logic [PCW-1:0]   LAST_PAIR = PCW'(NP - 1);
  localparam logic [2:0]       LAST_K    = 3'(KYBER_K - 1);
  localparam logic [DEPTH-1:0] RD_END    = DEPTH'(NP);
  localparam logic signed [PW-1:0] BV    = PW'(BARRETT_V);
  localparam logic signed [PW-1:0] QV    = PW'(Q);
  localparam logic signed [PW-1:0] RND   = PW'(33554432);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PCW-1:0]     pair_cnt_q, pair_cnt_d;
  logic [2:0]         k_cnt_q, k_cnt_d;
  logic               neg_q, neg_d;
  logic [DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_coef_1_q, out_coef_1_d;
  logic [WIDTH-1:0]   out_coef_2_q, out_coef_2_d;
  logic [DEPTH-1:0]   out_index_q, out_index_d;

  logic [2*WIDTH-1:0] acc_q [NP];
  logic               acc_we;
  logic [2*WIDTH-1:0] acc_wdata;
  logic [2*WIDTH-1:0] acc_rd;
  logic [2*WIDTH-1:0] rd_data;
  logic               beat;
  logic               load;
  logic               last_hs;

  // Centred Barrett reduction of one signed lane
  function automatic logic [WIDTH-1:0] barrett(input logic [WIDTH-1:0] a);
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] t;
    a_ext = PW'($signed(a));
    prod  = a_ext * BV;
    t     = (prod + RND) >>> 26;
    return WIDTH'(a_ext - t * QV);
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: the final ACC beat and the final output handshake advance the run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACC;
      S_ACC:   if (beat && pair_cnt_q == LAST_PAIR && k_cnt_q == LAST_K) state_d = S_DRAIN;
      S_DRAIN: if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state_q == S_ACC);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

  // Datapath: accumulate on accepted beats, refill the output register while draining
  always_comb begin
    pair_cnt_d   = pair_cnt_q;
    k_cnt_d      = k_cnt_q;
    neg_d        = neg_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid_q;
    out_coef_1_d = out_coef_1_q;
    out_coef_2_d = out_coef_2_q;
    out_index_d  = out_index_q;
    acc_we       = 1'b0;

    beat    = in_valid && (state_q == S_ACC);
    load    = (state_q == S_DRAIN) && (rd_ptr_q != RD_END) && (!out_valid_q || out_ready);
    last_hs = (state_q == S_DRAIN) && (rd_ptr_q == RD_END) && out_valid_q && out_ready;

    // Polynomial 0 overwrites the pair, so stale contents never leak into a run
    acc_rd = acc_q[pair_cnt_q];
    if (k_cnt_q == 3'd0)
      acc_wdata = {in_coef_1, in_coef_2};
    else if (neg_q)
      acc_wdata = {acc_rd[2*WIDTH-1:WIDTH] - in_coef_1, acc_rd[WIDTH-1:0] - in_coef_2};
    else
      acc_wdata = {acc_rd[2*WIDTH-1:WIDTH] + in_coef_1, acc_rd[WIDTH-1:0] + in_coef_2};

    if (state_q == S_IDLE && start) begin
      neg_d      = negate;
      pair_cnt_d = '0;
      k_cnt_d    = 3'd0;
      rd_ptr_d   = '0;
    end

    if (beat) begin
      acc_we     = 1'b1;
      pair_cnt_d = pair_cnt_q + 1'b1;
      // k_cnt stays at the last polynomial once accumulation finishes
      if (pair_cnt_q == LAST_PAIR && k_cnt_q != LAST_K) k_cnt_d = k_cnt_q + 3'd1;
    end

    rd_data = acc_q[rd_ptr_q[PCW-1:0]];
    if (load) begin
      out_valid_d  = 1'b1;
      out_coef_1_d = barrett(rd_data[2*WIDTH-1:WIDTH]);
      out_coef_2_d = barrett(rd_data[WIDTH-1:0]);
      out_index_d  = {rd_ptr_q[PCW-1:0], 1'b0};
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_cnt_q   <= '0;
      k_cnt_q      <= 3'd0;
      neg_q        <= 1'b0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_coef_1_q <= '0;
      out_coef_2_q <= '0;
      out_index_q  <= '0;
    end else begin
      pair_cnt_q   <= pair_cnt_d;
      k_cnt_q      <= k_cnt_d;
      neg_q        <= neg_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_coef_1_q <= out_coef_1_d;
      out_coef_2_q <= out_coef_2_d;
      out_index_q  <= out_index_d;
    end
  end

  // Accumulator storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (acc_we) acc_q[pair_cnt_q] <= acc_wdata;
  end

  assign out_valid  = out_valid_q;
  assign out_coef_1 = out_coef_1_q;
  assign out_coef_2 = out_coef_2_q;
  assign out_index  = out_index_q;
  assign k_cnt      = k_cnt_q;

endmodule

// File: tb/tb_polyvec_acc_reduce_k.sv
// tb/tb_polyvec_acc_reduce_k.sv - bench for polyvec_acc_reduce_k with K=2,3,4 instances
module tb_polyvec_acc_reduce_k;

  localparam int NP = 4;
  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        negate = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_c1 = '0;
  logic [15:0] in_c2 = '0;
  logic [1:0]  sel = 2'd0;

  logic        ir_w [3];
  logic        ov_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] c1_w [3];
  logic [15:0] c2_w [3];
  logic [2:0]  idx_w [3];
  logic [2:0]  k_w [3];

  logic        in_ready, ov, busy, done;
  logic [15:0] c1, c2;
  logic [2:0]  oidx, kc;

  int nchk = 0;
  int npass = 0;
  int in1_q[$];
  int in2_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    polyvec_acc_reduce_k #(.KYBER_K(g + 2), .DEPTH(3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start && (sel == g)),
      .negate    (negate),
      .in_valid  (in_valid && (sel == g)),
      .in_ready  (ir_w[g]),
      .in_coef_1 (in_c1),
      .in_coef_2 (in_c2),
      .out_valid (ov_w[g]),
      .out_ready (out_ready),
      .out_coef_1(c1_w[g]),
      .out_coef_2(c2_w[g]),
      .out_index (idx_w[g]),
      .k_cnt     (k_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );
  end

  always_comb begin
    in_ready = ir_w[sel];
    ov       = ov_w[sel];
    busy     = busy_w[sel];
    done     = done_w[sel];
    c1       = c1_w[sel];
    c2       = c2_w[sel];
    oidx     = idx_w[sel];
    kc       = k_w[sel];
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int wrap16(input int v);
    int m;
    m = v % 65536;
    if (m < 0) m += 65536;
    if (m >= 32768) m -= 65536;
    return m;
  endfunction

  function automatic int cred(input int v);
    int r;
    r = v % QM;
    if (r < 0) r += QM;
    if (r > (QM - 1) / 2) r -= QM;
    return r;
  endfunction

  task automatic fill_const(input int kk, input int a0, input int b0, input int a1, input int b1);
    in1_q.delete();
    in2_q.delete();
    for (int k = 0; k < kk; k++)
      for (int j = 0; j < NP; j++) begin
        in1_q.push_back(k == 0 ? a0 : a1);
        in2_q.push_back(k == 0 ? b0 : b1);
      end
  endtask

  task automatic fill_rand(input int kk);
    in1_q.delete();
    in2_q.delete();
    for (int b = 0; b < kk * NP; b++) begin
      in1_q.push_back(rnd16());
      in2_q.push_back(rnd16());
    end
  endtask

  task automatic begin_run(input logic [1:0] s, input bit neg);
    sel = s;
    @(negedge clk);
    start = 1'b1;
    negate = neg;
    @(negedge clk);
    start = 1'b0;
    negate = ~neg;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int nb, input int gapp, input int start_at);
    for (int b = 0; b < nb; b++) begin
      while (int'($urandom_range(0, 99)) < gapp) begin
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_c1 = 16'(in1_q[b]);
      in_c2 = 16'(in2_q[b]);
      start = (b == start_at);
      check("in_ready_acc", in_ready, 1);
      check("k_cnt_acc", kc, b / NP);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic drain(input int kk, input bit neg, input int rdyp, input int start_cyc, input bit junk);
    int e1 [NP];
    int e2 [NP];
    int s1, s2, idx, cyc;
    bit held;
    logic [15:0] h1, h2;
    logic [2:0]  hidx;
    for (int j = 0; j < NP; j++) begin
      s1 = in1_q[j];
      s2 = in2_q[j];
      for (int k = 1; k < kk; k++) begin
        s1 += neg ? -in1_q[k * NP + j] : in1_q[k * NP + j];
        s2 += neg ? -in2_q[k * NP + j] : in2_q[k * NP + j];
      end
      e1[j] = cred(wrap16(s1));
      e2[j] = cred(wrap16(s2));
    end
    check("in_ready_drain", in_ready, 0);
    check("k_cnt_drain", kc, kk - 1);
    idx = 0;
    cyc = 0;
    held = 1'b0;
    h1 = '0;
    h2 = '0;
    hidx = '0;
    while (idx < NP && cyc < 200) begin
      if (held) begin
        check("hold_valid", ov, 1);
        check("hold_c1", c1, h1);
        check("hold_c2", c2, h2);
        check("hold_index", oidx, hidx);
      end
      out_ready = (int'($urandom_range(0, 99)) < rdyp);
      start = (cyc == start_cyc);
      in_valid = junk;
      in_c1 = 16'($urandom);
      in_c2 = 16'($urandom);
      held = 1'b0;
      if (ov) begin
        if (out_ready) begin
          check("out_c1", $signed(c1), e1[idx]);
          check("out_c2", $signed(c2), e2[idx]);
          check("out_index", oidx, 2 * idx);
          idx++;
        end else begin
          held = 1'b1;
          h1 = c1;
          h2 = c2;
          hidx = oidx;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("drain_count", idx, NP);
    check("done_pulse", done, 1);
    check("valid_after_last", ov, 0);
    @(negedge clk);
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic run(input logic [1:0] s, input int kk, input bit neg, input int gapp,
                     input int rdyp, input int acc_start, input int drn_start, input bit junk);
    begin_run(s, neg);
    feed(kk * NP, gapp, acc_start);
    drain(kk, neg, rdyp, drn_start, junk);
  endtask

  initial begin
    // Reset state of all three instances
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", ov, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_c1", c1, 0);
      check("rst_c2", c2, 0);
      check("rst_index", oidx, 0);
      check("rst_k_cnt", kc, 0);
    end

    // in_valid while idle consumes nothing
    sel = 2'd0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    in_valid = 1'b0;

    // K=2 add: (1665,3329)+(0,-1) -> (-1664,-1)
    fill_const(2, 1665, 3329, 0, -1);
    run(2'd0, 2, 1'b0, 0, 100, -1, -1, 1'b0);

    // K=3 subtract: (10,20)-(3,4)-(3,4) -> (4,12)
    fill_const(3, 10, 20, 3, 4);
    run(2'd1, 3, 1'b1, 0, 100, -1, -1, 1'b0);

    // Random data, input gaps and output back-pressure on every K
    for (int r = 0; r < 6; r++) begin
      fill_rand(r % 3 + 2);
      run(2'(r % 3), r % 3 + 2, 1'($urandom), 50, 50, -1, -1, 1'b0);
    end

    // K=4 wrap: 4*32767 wraps to -4, 4*1 = 4
    fill_const(4, 32767, 1, 32767, 1);
    run(2'd2, 4, 1'b0, 0, 100, -1, -1, 1'b0);

    // Reset during ACC at k_cnt=1, then a clean run with fresh data
    fill_rand(3);
    begin_run(2'd1, 1'b0);
    feed(NP + 1, 0, -1);
    check("pre_reset_k_cnt", kc, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_k_cnt", kc, 0);
    check("mid_rst_valid", ov, 0);
    check("mid_rst_c1", c1, 0);
    check("mid_rst_index", oidx, 0);
    @(negedge clk);
    reset = 1'b0;
    fill_rand(3);
    run(2'd1, 3, 1'b1, 30, 70, -1, -1, 1'b0);

    // Stray start pulses in ACC and DRAIN, junk in_valid while draining
    fill_rand(3);
    run(2'd1, 3, 1'b0, 20, 60, 5, 2, 1'b1);
    fill_rand(2);
    run(2'd0, 2, 1'b1, 0, 100, 1, 1, 1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
